// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one DRAM port between the I-cache refill and D-cache paths.
// Ports: clk, rst_n, I side (i_oe/i_addr -> i_rdata/i_valid), D side
// (d_oe/d_we/d_addr/d_wdata -> d_rdata/d_valid), DRAM side (m_oe/m_we/m_addr/
// m_wdata -> m_rdata/m_valid), busy. Optional macro MEM_ARBITER_STAT_EN adds
// grant and wait counters arb_cnt_i, arb_cnt_d, arb_cnt_wait.
module mem_arbiter #(
    parameter int unsigned MEM_SCALE = 27,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_oe,
    input  logic [MEM_SCALE-1:0] i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_valid,
    input  logic                 d_oe,
    input  logic                 d_we,
    input  logic [MEM_SCALE-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_valid,
    output logic                 m_oe,
    output logic                 m_we,
    output logic [MEM_SCALE-1:0] m_addr,
    output logic [31:0]          m_wdata,
    input  logic [31:0]          m_rdata,
    input  logic                 m_valid,
    output logic                 busy
`ifdef MEM_ARBITER_STAT_EN
    ,
    output logic [31:0]          arb_cnt_i,
    output logic [31:0]          arb_cnt_d,
    output logic [31:0]          arb_cnt_wait
`endif
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_e                 state_q;
    logic                   owner_q;
    logic                   last_q;

    logic                   i_pend_q;
    logic [MEM_SCALE-1:0]   i_addr_q;

    logic                   d_pend_q;
    logic                   d_we_q;
    logic [MEM_SCALE-1:0]   d_addr_q;
    logic [31:0]            d_wdata_q;

    logic                   m_oe_q;
    logic                   m_we_q;
    logic [MEM_SCALE-1:0]   m_addr_q;
    logic [31:0]            m_wdata_q;
    logic                   busy_q;

    logic                   in_wait;
    logic                   done;
    logic                   done_i;
    logic                   done_d;
    logic                   arb_en;
    logic                   cap_i;
    logic                   cap_d;
    logic                   cand_i;
    logic                   cand_d;
    logic                   tie;
    logic                   grant;
    logic                   pick_d;
    logic                   last_d;

    logic [MEM_SCALE-1:0]   i_addr_sel;
    logic                   d_we_sel;
    logic [MEM_SCALE-1:0]   d_addr_sel;
    logic [31:0]            d_wdata_sel;

    logic                   m_we_d;
    logic [MEM_SCALE-1:0]   m_addr_d;
    logic [31:0]            m_wdata_d;

    assign in_wait = (state_q == WAIT);
    assign done    = in_wait & m_valid;
    assign done_i  = done & (owner_q == SIDE_I);
    assign done_d  = done & (owner_q == SIDE_D);

    // Arbitration runs in IDLE and also in the completion cycle, so the
    // next DRAM request can go out the cycle right after m_valid.
    assign arb_en  = ~in_wait | done;

    // A side holding a request (pending or in service) ignores new oe pulses.
    assign cap_i   = i_oe & ~i_pend_q;
    assign cap_d   = d_oe & ~d_pend_q;

    // The completing owner drops out; a fresh oe is eligible immediately.
    assign cand_i  = arb_en & (i_pend_q ? ~done_i : i_oe);
    assign cand_d  = arb_en & (d_pend_q ? ~done_d : d_oe);
    assign tie     = cand_i & cand_d;
    assign grant   = cand_i | cand_d;

    assign i_addr_sel  = i_pend_q ? i_addr_q  : i_addr;
    assign d_we_sel    = d_pend_q ? d_we_q    : d_we;
    assign d_addr_sel  = d_pend_q ? d_addr_q  : d_addr;
    assign d_wdata_sel = d_pend_q ? d_wdata_q : d_wdata;

    // Only genuine ties move the round-robin pointer.
    always_comb begin
        pick_d = cand_d;
        last_d = last_q;
        if (tie) begin
            pick_d = (ARB_MODE != 0) || (last_q == SIDE_I);
            if (ARB_MODE == 0) begin
                last_d = pick_d;
            end
        end
    end

    always_comb begin
        m_we_d    = 1'b0;
        m_addr_d  = i_addr_sel;
        m_wdata_d = '0;
        if (pick_d) begin
            m_we_d    = d_we_sel;
            m_addr_d  = d_addr_sel;
            m_wdata_d = d_wdata_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= SIDE_I;
            last_q    <= SIDE_D;
            i_pend_q  <= 1'b0;
            i_addr_q  <= '0;
            d_pend_q  <= 1'b0;
            d_we_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            m_oe_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (cap_i) begin
                i_pend_q <= 1'b1;
                i_addr_q <= i_addr;
            end else if (done_i) begin
                i_pend_q <= 1'b0;
            end

            if (cap_d) begin
                d_pend_q  <= 1'b1;
                d_we_q    <= d_we;
                d_addr_q  <= d_addr;
                d_wdata_q <= d_wdata;
            end else if (done_d) begin
                d_pend_q <= 1'b0;
            end

            m_oe_q <= grant;

            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (m_valid && !grant) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (grant) begin
                owner_q   <= pick_d;
                last_q    <= last_d;
                m_we_q    <= m_we_d;
                m_addr_q  <= m_addr_d;
                m_wdata_q <= m_wdata_d;
            end
        end
    end

    assign m_oe    = m_oe_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

    // A stray m_valid in IDLE never reaches a requester.
    assign i_valid = done_i;
    assign d_valid = done_d;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

`ifdef MEM_ARBITER_STAT_EN
    logic        grant_i;
    logic        grant_d;
    logic        wait_i;
    logic        wait_d;
    logic [31:0] cnt_i_q;
    logic [31:0] cnt_d_q;
    logic [31:0] cnt_wait_q;

    assign grant_i = grant & ~pick_d;
    assign grant_d = grant & pick_d;

    // Waiting means holding a request that is neither in service nor
    // being granted this cycle.
    assign wait_i = i_pend_q & ~(in_wait & (owner_q == SIDE_I)) & ~grant_i;
    assign wait_d = d_pend_q & ~(in_wait & (owner_q == SIDE_D)) & ~grant_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_i_q    <= '0;
            cnt_d_q    <= '0;
            cnt_wait_q <= '0;
        end else begin
            cnt_i_q    <= cnt_i_q + 32'(grant_i);
            cnt_d_q    <= cnt_d_q + 32'(grant_d);
            cnt_wait_q <= cnt_wait_q + 32'(wait_i) + 32'(wait_d);
        end
    end

    assign arb_cnt_i    = cnt_i_q;
    assign arb_cnt_d    = cnt_d_q;
    assign arb_cnt_wait = cnt_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter in both
// arbitration modes against a request-level reference model.
module tb_mem_arbiter;

    localparam int AW = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          i_oe;
    logic [AW-1:0] i_addr;
    logic          d_oe;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   m_rdata;
    logic          m_valid;

    logic [31:0]   w_i_rdata [2];
    logic          w_i_valid [2];
    logic [31:0]   w_d_rdata [2];
    logic          w_d_valid [2];
    logic          w_m_oe    [2];
    logic          w_m_we    [2];
    logic [AW-1:0] w_m_addr  [2];
    logic [31:0]   w_m_wdata [2];
    logic          w_busy    [2];
`ifdef MEM_ARBITER_STAT_EN
    logic [31:0]   w_ci [2];
    logic [31:0]   w_cd [2];
    logic [31:0]   w_cw [2];
`endif

    mem_arbiter #(.MEM_SCALE(AW), .ARB_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_oe(i_oe), .i_addr(i_addr),
        .i_rdata(w_i_rdata[0]), .i_valid(w_i_valid[0]),
        .d_oe(d_oe), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(w_d_rdata[0]), .d_valid(w_d_valid[0]),
        .m_oe(w_m_oe[0]), .m_we(w_m_we[0]), .m_addr(w_m_addr[0]),
        .m_wdata(w_m_wdata[0]), .m_rdata(m_rdata), .m_valid(m_valid),
        .busy(w_busy[0])
`ifdef MEM_ARBITER_STAT_EN
        , .arb_cnt_i(w_ci[0]), .arb_cnt_d(w_cd[0]), .arb_cnt_wait(w_cw[0])
`endif
    );

    mem_arbiter #(.MEM_SCALE(AW), .ARB_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_oe(i_oe), .i_addr(i_addr),
        .i_rdata(w_i_rdata[1]), .i_valid(w_i_valid[1]),
        .d_oe(d_oe), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(w_d_rdata[1]), .d_valid(w_d_valid[1]),
        .m_oe(w_m_oe[1]), .m_we(w_m_we[1]), .m_addr(w_m_addr[1]),
        .m_wdata(w_m_wdata[1]), .m_rdata(m_rdata), .m_valid(m_valid),
        .busy(w_busy[1])
`ifdef MEM_ARBITER_STAT_EN
        , .arb_cnt_i(w_ci[1]), .arb_cnt_d(w_cd[1]), .arb_cnt_wait(w_cw[1])
`endif
    );

    bit            sel;
    logic [31:0]   o_i_rdata;
    logic          o_i_valid;
    logic [31:0]   o_d_rdata;
    logic          o_d_valid;
    logic          o_m_oe;
    logic          o_m_we;
    logic [AW-1:0] o_m_addr;
    logic [31:0]   o_m_wdata;
    logic          o_busy;
`ifdef MEM_ARBITER_STAT_EN
    logic [31:0]   o_ci;
    logic [31:0]   o_cd;
    logic [31:0]   o_cw;
`endif

    always_comb begin
        o_i_rdata = w_i_rdata[sel];
        o_i_valid = w_i_valid[sel];
        o_d_rdata = w_d_rdata[sel];
        o_d_valid = w_d_valid[sel];
        o_m_oe    = w_m_oe[sel];
        o_m_we    = w_m_we[sel];
        o_m_addr  = w_m_addr[sel];
        o_m_wdata = w_m_wdata[sel];
        o_busy    = w_busy[sel];
`ifdef MEM_ARBITER_STAT_EN
        o_ci      = w_ci[sel];
        o_cd      = w_cd[sel];
        o_cw      = w_cw[sel];
`endif
    end

    int checks = 0;
    int fails  = 0;

    // Reference model: one request slot per side, one outstanding DRAM access.
    int            mode;
    bit            mb;
    bit            mown;
    bit            last;
    bit            mpend [2];
    logic [AW-1:0] maddr [2];
    bit            mwe;
    logic [31:0]   mwd;
    bit            emoe;
    bit            ewe;
    logic [AW-1:0] eaddr;
    logic [31:0]   ewd;
    int            gcnt [2];

    // DRAM model, driven by what the DUT actually puts on the bus.
    bit            dram_auto;
    bit            stray_en;
    int            dcnt;
    logic [31:0]   dram_rd;
    logic [31:0]   mem [bit [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mb       = 1'b0;
        mown     = 1'b0;
        last     = 1'b1;
        mpend[0] = 1'b0;
        mpend[1] = 1'b0;
        emoe     = 1'b0;
        ewe      = 1'b0;
        eaddr    = '0;
        ewd      = '0;
        gcnt[0]  = 0;
        gcnt[1]  = 0;
    endtask

    task automatic model_step();
        bit comp;
        bit s;
        comp = mb && m_valid;
        if (i_oe && !mpend[0]) begin
            mpend[0] = 1'b1;
            maddr[0] = i_addr;
        end
        if (d_oe && !mpend[1]) begin
            mpend[1] = 1'b1;
            maddr[1] = d_addr;
            mwe      = d_we;
            mwd      = d_wdata;
        end
        if (comp) mpend[mown] = 1'b0;
        emoe = 1'b0;
        if (!mb || comp) begin
            if (mpend[0] && mpend[1]) begin
                s = (mode == 1) ? 1'b1 : !last;
                if (mode == 0) last = s;
            end else begin
                s = mpend[1];
            end
            if (mpend[0] || mpend[1]) begin
                emoe  = 1'b1;
                mb    = 1'b1;
                mown  = s;
                eaddr = maddr[s];
                ewe   = s && mwe;
                ewd   = s ? mwd : 32'h0;
                gcnt[s]++;
            end else begin
                mb = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        if (dram_auto) begin
            m_valid = 1'b0;
            m_rdata = $urandom;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    m_valid = 1'b1;
                    m_rdata = dram_rd;
                end
            end else if (stray_en && !mb && $urandom_range(0, 15) == 0) begin
                m_valid = 1'b1;
            end
        end
        #1;
        chk("m_oe", o_m_oe, emoe);
        chk("busy", o_busy, mb);
        if (mb) begin
            chk("m_addr", o_m_addr, eaddr);
            chk("m_we", o_m_we, ewe);
            if (ewe) chk("m_wdata", o_m_wdata, ewd);
        end
        chk("i_valid", o_i_valid, mb && m_valid && !mown);
        chk("d_valid", o_d_valid, mb && m_valid && mown);
        chk("i_rdata", o_i_rdata, m_rdata);
        chk("d_rdata", o_d_rdata, m_rdata);
        if (o_m_oe === 1'b1) begin
            if (o_m_we === 1'b1) begin
                mem[o_m_addr] = o_m_wdata;
                dram_rd = $urandom;
            end else if (mem.exists(o_m_addr)) begin
                dram_rd = mem[o_m_addr];
            end else begin
                dram_rd = 32'h0BAD0000 ^ 32'(o_m_addr);
            end
            if (dram_auto) dcnt = $urandom_range(1, 4);
        end
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        i_oe = 1'b0;
        d_oe = 1'b0;
        if (!dram_auto) m_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        m_valid = 1'b1;
        m_rdata = data;
        cyc();
    endtask

    task automatic hard_reset(input bit which, input int md);
        sel     = which;
        mode    = md;
        rst_n   = 1'b0;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic run_random(input int n);
        dram_auto = 1'b1;
        stray_en  = 1'b1;
        dcnt      = 0;
        for (int k = 0; k < n; k++) begin
            i_oe    = ($urandom_range(0, 3) == 0);
            i_addr  = AW'($urandom_range(0, 63));
            d_oe    = ($urandom_range(0, 2) == 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = AW'($urandom_range(0, 63));
            d_wdata = $urandom;
            cyc();
        end
        stray_en = 1'b0;
        repeat (12) cyc();
        dram_auto = 1'b0;
        m_valid   = 1'b0;
`ifdef MEM_ARBITER_STAT_EN
        chk("cnt_i", o_ci, 32'(gcnt[0]));
        chk("cnt_d", o_cd, 32'(gcnt[1]));
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        i_oe      = 1'b0;
        i_addr    = '0;
        d_oe      = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        m_valid   = 1'b0;
        m_rdata   = '0;
        dram_auto = 1'b0;
        stray_en  = 1'b0;
        dcnt      = 0;
        repeat (2) @(posedge clk);
        #1;

        hard_reset(1'b0, 0);
        #1;
        chk("rst_m_addr", o_m_addr, 0);
        chk("rst_m_wdata", o_m_wdata, 0);
        chk("rst_m_we", o_m_we, 0);
        cyc();

        i_oe   = 1'b1;
        i_addr = AW'('h100);
        cyc();
        #1;
        chk("t1_m_oe", o_m_oe, 1);
        chk("t1_m_addr", o_m_addr, 'h100);
        chk("t1_m_we", o_m_we, 0);
        cyc();
        repeat (3) cyc();
        m_valid = 1'b1;
        m_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_i_valid", o_i_valid, 1);
        chk("t1_i_rdata", o_i_rdata, 32'hDEADBEEF);
        chk("t1_d_valid", o_d_valid, 0);
        cyc();
        #1;
        chk("t1_busy_low", o_busy, 0);
        cyc();

        i_oe    = 1'b1;
        i_addr  = AW'('h200);
        d_oe    = 1'b1;
        d_we    = 1'b1;
        d_addr  = AW'('h300);
        d_wdata = 32'hCAFE0001;
        cyc();
        #1;
        chk("t2_tie_i_first", o_m_addr, 'h200);
        cyc();
        cyc();
        respond(32'h11111111);
        #1;
        chk("t2_d_issue", o_m_oe, 1);
        chk("t2_d_we", o_m_we, 1);
        chk("t2_d_wdata", o_m_wdata, 32'hCAFE0001);
        cyc();
        respond(32'h0);
        cyc();
        i_oe   = 1'b1;
        i_addr = AW'('h204);
        d_oe   = 1'b1;
        d_we   = 1'b0;
        d_addr = AW'('h304);
        cyc();
        #1;
        chk("t2_tie2_d_first", o_m_addr, 'h304);
        cyc();
        respond(32'h22222222);
        #1;
        chk("t2_i_after", o_m_addr, 'h204);
        cyc();
        respond(32'h33333333);
        cyc();

        d_oe    = 1'b1;
        d_we    = 1'b1;
        d_addr  = AW'('h40);
        d_wdata = 32'h12345678;
        cyc();
        #1;
        chk("t4_m_we", o_m_we, 1);
        chk("t4_m_wdata", o_m_wdata, 32'h12345678);
        cyc();
        cyc();
        m_valid = 1'b1;
        m_rdata = 32'h0;
        #1;
        chk("t4_d_valid", o_d_valid, 1);
        cyc();
        chk("t4_mem", mem.exists(AW'('h40)) ? mem[AW'('h40)] : 32'hX,
            32'h12345678);

        i_oe   = 1'b1;
        i_addr = AW'('h500);
        cyc();
        i_oe   = 1'b1;
        i_addr = AW'('h600);
        cyc();
        i_oe   = 1'b1;
        i_addr = AW'('h680);
        cyc();
        respond(32'h55555555);
        repeat (2) cyc();

        i_oe   = 1'b1;
        i_addr = AW'('h700);
        cyc();
        cyc();
        m_valid = 1'b1;
        m_rdata = 32'h77777777;
        i_oe    = 1'b1;
        i_addr  = AW'('h780);
        d_oe    = 1'b1;
        d_we    = 1'b0;
        d_addr  = AW'('h710);
        cyc();
        #1;
        chk("t5_d_next", o_m_addr, 'h710);
        chk("t5_d_next_oe", o_m_oe, 1);
        cyc();
        respond(32'h71071071);
        repeat (2) cyc();
        m_valid = 1'b1;
        #1;
        chk("t5_stray_i", o_i_valid, 0);
        chk("t5_stray_d", o_d_valid, 0);
        cyc();

        i_oe   = 1'b1;
        i_addr = AW'('h800);
        cyc();
        d_oe   = 1'b1;
        d_addr = AW'('h900);
        rst_n  = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t6_busy", o_busy, 0);
`ifdef MEM_ARBITER_STAT_EN
        chk("t6_cnt_i", o_ci, 0);
        chk("t6_cnt_d", o_cd, 0);
        chk("t6_cnt_wait", o_cw, 0);
`endif
        cyc();
        m_valid = 1'b1;
        #1;
        chk("t6_late_i", o_i_valid, 0);
        chk("t6_late_d", o_d_valid, 0);
        cyc();
        repeat (3) cyc();

        mode = 0;
        run_random(400);

        hard_reset(1'b1, 1);
        i_oe   = 1'b1;
        i_addr = AW'('hA00);
        d_oe   = 1'b1;
        d_we   = 1'b0;
        d_addr = AW'('hB00);
        cyc();
        #1;
        chk("t3_d_first", o_m_addr, 'hB00);
        cyc();
        cyc();
        respond(32'hB0B0B0B0);
        #1;
        chk("t3_i_next", o_m_addr, 'hA00);
        cyc();
        respond(32'hA0A0A0A0);
        cyc();

        run_random(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single DRAM port between the instruction-cache refill path and the data-cache path.
- Requester ports use the cache "super" protocol: a one-cycle oe pulse with address, answered later by a one-cycle valid pulse with data.
- Holds at most one outstanding DRAM transaction.
- Sits between ICACHE/DCACHE and the DRAM controller.

Parameters:
- MEM_SCALE, 27, byte-address width of DRAM port and requester addresses.
- ARB_MODE, 0, 0 = round-robin between I and D; 1 = D always wins ties.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- i_oe  in  1  I-side read request pulse.
- i_addr  in  MEM_SCALE  I-side address, sampled with i_oe.
- i_rdata  out  32  I-side read data, valid with i_valid.
- i_valid  out  1  I-side completion pulse.
- d_oe  in  1  D-side request pulse.
- d_we  in  1  D-side write when 1, read when 0; sampled with d_oe.
- d_addr  in  MEM_SCALE  D-side address, sampled with d_oe.
- d_wdata  in  32  D-side write data, sampled with d_oe.
- d_rdata  out  32  D-side read data.
- d_valid  out  1  D-side completion pulse; for writes it is the ack.
- m_oe  out  1  DRAM request pulse.
- m_we  out  1  DRAM write enable, qualified by m_oe.
- m_addr  out  MEM_SCALE  DRAM address.
- m_wdata  out  32  DRAM write data.
- m_rdata  in  32  DRAM read data.
- m_valid  in  1  DRAM completion pulse.
- busy  out  1  high while a DRAM transaction is outstanding.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE; i_pend and d_pend clear.
  - last_grant is set to D, so the first tie goes to I in round-robin mode.
  - m_oe, m_we, i_valid, d_valid and busy are 0; m_addr and m_wdata are 0.
- Capture:
  - i_oe at edge t sets i_pend and latches i_addr.
  - d_oe at edge t sets d_pend and latches d_we, d_addr and d_wdata.
  - An oe from a requester that already has a pending or in-service request is ignored. Pending contents are unchanged.
- FSM states: IDLE, WAIT.
  - In IDLE, the candidate set is (pending | oe this cycle) for each side, so a fresh oe is eligible in the same cycle.
  - If any candidate exists: choose owner, register m_oe=1 for exactly one cycle (t+1), and drive m_we/m_addr/m_wdata from the owner's request (registered, stable until completion). Go to WAIT and set busy=1.
  - Choice with one candidate: take it.
  - Choice with two candidates: ARB_MODE=1 picks D. ARB_MODE=0 picks the side not equal to last_grant, then updates last_grant.
  - In WAIT:
    - On m_valid, assert owner's valid the same cycle (combinational).
    - The owner's rdata output is m_rdata.
    - Clear the owner's pend, go to IDLE and drop busy the next cycle.
    - The non-owner's valid stays 0.
- Latency:
  - Minimum from requester oe to m_oe is 1 cycle.
  - Requester valid coincides with m_valid.
  - Back-to-back: the earliest next m_oe is the cycle after m_valid.
- Outside WAIT:
  - i_rdata and d_rdata pass m_rdata regardless.
  - m_valid received in IDLE (stray, e.g. after a mid-transaction reset) is dropped: no requester valid.
- Simultaneous events:
  - m_valid and a new oe from the completing owner in the same cycle: the oe is ignored, because the owner is still in service that cycle.
  - oe from the other side in that cycle is captured normally.
- Reset mid-transaction: the outstanding transaction is abandoned and requesters receive no valid. Caches are reset by the same reset, so this is consistent.

Optional Feature:
- Macro: MEM_ARBITER_STAT_EN.
- Defined: adds outputs arb_cnt_i, arb_cnt_d and arb_cnt_wait (32 bits each, zeroed on reset).
  - arb_cnt_i increments per I grant; arb_cnt_d increments per D grant.
  - arb_cnt_wait increments each cycle a side is pending but not granted (+1 per waiting side).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Single I read: i_oe at cycle 5 with i_addr=0x100. Expect m_oe=1, m_we=0, m_addr=0x100 at cycle 6. DRAM returns m_valid at cycle 10 with m_rdata=0xDEADBEEF. Expect i_valid=1, i_rdata=0xDEADBEEF at cycle 10; d_valid=0; busy=0 at cycle 11.
2. Tie, ARB_MODE=0 after reset: i_oe and d_oe both at cycle 3. Expect I granted first (m_addr=i_addr at cycle 4). After m_valid, D is issued the cycle after, with m_we and m_wdata from the D request. The next tie goes to D.
3. Tie, ARB_MODE=1: repeat test 2. D must be granted first, then I.
4. D write: d_oe, d_we=1, d_addr=0x40, d_wdata=0x12345678. Expect m_oe with m_we=1, m_wdata=0x12345678. d_valid pulses with m_valid. Captured DRAM model memory[0x40] equals 0x12345678.
5. Protocol edges:
   - A second i_oe while I is pending is ignored: exactly one m_oe for I.
   - d_oe in the same cycle as m_valid for I is captured and issued next cycle.
   - A stray m_valid in IDLE produces no valid.
6. Reset mid-WAIT: rst_n low for 1 cycle after m_oe. Expect busy=0 and no pending requests. A later m_valid yields i_valid=d_valid=0. With MEM_ARBITER_STAT_EN, all counters read 0.
